// File: rtl/oc8051_symbolic_cxrom_lazy_if.sv
// Bus bundle for the symbolic code ROM: one multi-byte implementation fetch port
// and GM_PORTS golden-model byte ports, all combinational reads.
interface oc8051_symbolic_cxrom_lazy_if #(
    parameter int FETCH_BYTES = 4,
    parameter int GM_PORTS    = 3
);
    logic [15:0]               cxrom_addr;
    logic                      cxrom_rd;
    logic [FETCH_BYTES*8-1:0]  cxrom_data_out;
    logic [GM_PORTS*16-1:0]    rd_addr;
    logic [GM_PORTS-1:0]       rd_en;
    logic [GM_PORTS*8-1:0]     rd_data;

    modport master (
        output cxrom_addr, cxrom_rd, rd_addr, rd_en,
        input  cxrom_data_out, rd_data
    );

    modport slave (
        input  cxrom_addr, cxrom_rd, rd_addr, rd_en,
        output cxrom_data_out, rd_data
    );
endinterface

// File: rtl/oc8051_symbolic_cxrom_lazy.sv
// Symbolic code ROM whose cells bind to word_in on first strobed read (lazy latching).
// Define OC8051_SYMROM_ALIAS_EN to wrap addresses modulo DEPTH instead of flagging out-of-range.
module oc8051_symbolic_cxrom_lazy #(
    parameter int DEPTH_LOG2  = 4,
    parameter int FETCH_BYTES = 4,
    parameter int GM_PORTS    = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [(1<<DEPTH_LOG2)*8-1:0]   word_in,
    oc8051_symbolic_cxrom_lazy_if.slave    bus,
    output logic [(1<<DEPTH_LOG2)-1:0]     latched,
    output logic [DEPTH_LOG2:0]            used_cnt,
    output logic                           all_latched,
    output logic                           oob_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int NACC  = FETCH_BYTES + GM_PORTS;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [7:0]            data_reg [DEPTH];
    logic [DEPTH-1:0]      latched_reg;
    logic [CW-1:0]         used_cnt_reg;
    logic                  oob_err_reg;

    logic [7:0]            cell_val [DEPTH];
    logic [15:0]           acc_addr [NACC];
    logic [NACC-1:0]       acc_en;
    logic [NACC-1:0]       acc_inr;
    logic [DEPTH_LOG2-1:0] acc_idx  [NACC];
    logic [7:0]            acc_data [NACC];
    logic [DEPTH-1:0]      hit;
    logic [DEPTH-1:0]      bind_next;
    logic [CW-1:0]         bind_cnt;
    logic                  oob_next;

    genvar gi;
    generate
        // Unbound cells bypass word_in so the first reader sees exactly the value that gets bound.
        for (gi = 0; gi < DEPTH; gi++) begin : g_cell
            assign cell_val[gi] = latched_reg[gi] ? data_reg[gi] : word_in[8*gi +: 8];
        end
        for (gi = 0; gi < FETCH_BYTES; gi++) begin : g_fetch
            assign acc_addr[gi] = bus.cxrom_addr + 16'(gi);
            assign acc_en[gi]   = bus.cxrom_rd;
            assign bus.cxrom_data_out[8*gi +: 8] = acc_data[gi];
        end
        for (gi = 0; gi < GM_PORTS; gi++) begin : g_gm
            assign acc_addr[FETCH_BYTES+gi] = bus.rd_addr[16*gi +: 16];
            assign acc_en[FETCH_BYTES+gi]   = bus.rd_en[gi];
            assign bus.rd_data[8*gi +: 8]   = acc_data[FETCH_BYTES+gi];
        end
        for (gi = 0; gi < NACC; gi++) begin : g_acc
            assign acc_idx[gi] = acc_addr[gi][DEPTH_LOG2-1:0];
`ifdef OC8051_SYMROM_ALIAS_EN
            assign acc_inr[gi] = 1'b1;
`else
            assign acc_inr[gi] = (32'(acc_addr[gi]) < 32'(DEPTH));
`endif
            assign acc_data[gi] = acc_inr[gi] ? cell_val[acc_idx[gi]] : 8'h00;
        end
    endgenerate

    // Several ports hitting one cell collapse into a single bind.
    always_comb begin
        hit      = '0;
        oob_next = 1'b0;
        for (int a = 0; a < NACC; a++) begin
            if (acc_en[a] && acc_inr[a])
                hit[acc_idx[a]] = 1'b1;
            if (acc_en[a] && !acc_inr[a])
                oob_next = 1'b1;
        end
        bind_next = hit & ~latched_reg;
        bind_cnt  = '0;
        for (int i = 0; i < DEPTH; i++)
            bind_cnt = bind_cnt + CW'(bind_next[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            latched_reg  <= '0;
            used_cnt_reg <= '0;
            oob_err_reg  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                data_reg[i] <= 8'h00;
        end else begin
            latched_reg  <= latched_reg | bind_next;
            used_cnt_reg <= used_cnt_reg + bind_cnt;
            oob_err_reg  <= oob_err_reg | oob_next;
            for (int i = 0; i < DEPTH; i++)
                if (bind_next[i])
                    data_reg[i] <= word_in[8*i +: 8];
        end
    end

    assign latched     = latched_reg;
    assign used_cnt    = used_cnt_reg;
    assign all_latched = (used_cnt_reg == CW'(DEPTH));
    assign oob_err     = oob_err_reg;
endmodule

// File: doc/oc8051_symbolic_cxrom_lazy.md
# oc8051_symbolic_cxrom_lazy

Parametrised symbolic code ROM for formal equivalence of the oc8051 core against the golden model. Each byte cell takes its value from a free symbolic input and freezes it at the first cycle the cell is actually read (lazy latching), so untouched cells stay unconstrained. One multi-byte fetch port serves the 8051 implementation; GM_PORTS byte ports serve the golden model. Status outputs report which cells are bound, how many, and whether any access fell outside the ROM.

## Interface
- DEPTH_LOG2, 4: log2 of cell count; DEPTH = 2**DEPTH_LOG2 (1..12).
- FETCH_BYTES, 4: bytes returned per implementation fetch (1..8).
- GM_PORTS, 3: golden-model byte read ports (1..8).
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- word_in  in  DEPTH*8  symbolic cell values; cell i is word_in[8i+7:8i].
- cxrom_addr  in  16  implementation fetch base address.
- cxrom_rd  in  1  fetch strobe; binds accessed cells.
- cxrom_data_out  out  FETCH_BYTES*8  byte j = cell at cxrom_addr+j, LSB first.
- rd_addr  in  GM_PORTS*16  golden-model addresses, port k at [16k+15:16k].
- rd_en  in  GM_PORTS  per-port read strobe; binds accessed cell.
- rd_data  out  GM_PORTS*8  port k data at [8k+7:8k].
- latched  out  DEPTH  per-cell bound flag.
- used_cnt  out  DEPTH_LOG2+1  number of bound cells.
- all_latched  out  1  used_cnt == DEPTH.
- oob_err  out  1  sticky out-of-range access flag.

## Operation
- Cell state: latched[i], data[i][7:0]. Cell value = latched[i] ? data[i] : word_in slice i (bypass, so the first reader sees exactly the value that gets bound).
- Reads are combinational from cell value; data outputs ignore strobes (strobes only affect binding and oob_err).
- Access set each cycle: bytes cxrom_addr+j (j < FETCH_BYTES) if cxrom_rd; rd_addr[k] if rd_en[k].
- On posedge, every in-range accessed cell with latched=0 sets latched=1, data=word_in slice. Bound cells never change until reset.
- Same cell hit by several ports in one cycle: bound once, all ports see identical value.
- used_cnt += number of cells newly bound this cycle (popcount of new binds, 0..FETCH_BYTES+GM_PORTS); invariant used_cnt == popcount(latched). Saturates naturally at DEPTH.
- Address arithmetic: cxrom_addr+j computed 16-bit, wrapping 16'hFFFF -> 16'h0000.
- Range handling per Configuration.
- Reset values: latched=0, data=0, used_cnt=0, all_latched=0, oob_err=0; data outputs then follow word_in bypass.

## Timing
- Read latency 0 cycles (combinational addr -> data).
- Bind takes effect at the edge ending the access cycle; latched/used_cnt/all_latched visible the following cycle.
- oob_err sets at the edge ending the offending strobed cycle; stays set until rst.
- rst assertion mid-operation clears all state immediately (asynchronous), independent of clk; deassertion with an access pending binds at the first posedge after release.
- No handshake; strobes are sampled every cycle, no back-pressure.

## Configuration
- OC8051_SYMROM_ALIAS_EN defined: address used modulo DEPTH (low DEPTH_LOG2 bits); every access is in range; oob_err tied 0.
- Undefined: an address >= DEPTH (full 16-bit compare) is out of range: byte returns 8'h00, binds nothing, and if its strobe is active sets oob_err. Fetch bytes are checked individually, so a fetch straddling the top returns valid low bytes and 8'h00 above.

## Test plan
- Reset then cxrom_rd=1, cxrom_addr=0, word_in bytes 0..3 = 11,22,33,44: data_out=32'h44332211 same cycle; next cycle latched=16'h000F, used_cnt=4; change word_in bytes to FF -> data_out still 32'h44332211.
- No strobes for 10 cycles, word_in changing: latched=0, used_cnt=0, rd_data tracks word_in every cycle.
- rd_en=3'b111, all rd_addr=5, cxrom_rd=1 addr=4: next cycle latched=16'h00F0, used_cnt=4 (cell 5 counted once), all four reads equal.
- ALIAS_EN: cxrom_addr=16'h000E, FETCH_BYTES=4 -> bytes from cells E,F,0,1; latched=16'hC003. Without ALIAS_EN: bytes 2,3 read 00, latched=16'hC000, oob_err=1 next cycle and sticky.
- Without ALIAS_EN: rd_addr=16'hFFFF, rd_en=0 -> rd_data=00, oob_err stays 0; rd_en=1 -> oob_err=1.
- Bind all 16 cells, assert rst low asynchronously between edges: latched=0, used_cnt=0, all_latched=0 immediately; after release, data follows new word_in.
